// File: rtl/avg_pool_layer.sv
// ---------------------------------------------------------------------------
// avg_pool_layer
//   2x2 / stride-2 average pooling over a stack of NxN row-major feature maps
//   held in word-addressed DMA memory. Reads four input words per output,
//   sums them in a DATA_W+2 accumulator and writes sum >>> 2 back to memory.
//   One output word costs six cycles: R0..R3 (reads), ACC, WR.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset (aborts any operation)
//   enable       start request, only looked at in IDLE; also holds DONE
//   mapsNumber   number of input maps             (latched at start)
//   mapSize      input side length N              (latched at start)
//   inAddress    base address of map 0 input      (latched at start)
//   outAddress   base address of map 0 output     (latched at start)
//   readEnable   memory read strobe
//   readAddr     memory read address (0 when not reading)
//   readData     signed read data, valid one cycle after readEnable
//   writeEnable  memory write strobe, one pulse per pooled word
//   writeAddr    memory write address (0 when not writing)
//   writeOut     signed pooled value (0 when not writing)
//   done         high while in DONE
// ---------------------------------------------------------------------------
module avg_pool_layer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] mapsNumber,
  input  logic [DATA_W-1:0] mapSize,
  input  logic [DATA_W-1:0] inAddress,
  input  logic [DATA_W-1:0] outAddress,
  output logic              readEnable,
  output logic [DATA_W-1:0] readAddr,
  input  logic [DATA_W-1:0] readData,
  output logic              writeEnable,
  output logic [DATA_W-1:0] writeAddr,
  output logic [DATA_W-1:0] writeOut,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_R0, S_R1, S_R2, S_R3, S_ACC, S_WR, S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched job parameters
  logic [DATA_W-1:0] maps_q;    // number of maps
  logic [DATA_W-1:0] n_q;       // input side N
  logic [DATA_W-1:0] msz_q;     // output side M = N/2
  logic [DATA_W-1:0] nn_q;      // N*N, stride between input maps

  // Iteration counters
  logic [DATA_W-1:0] c_q, r_q, m_q;

  // Address pointers. a_q is the top-left input address of the current
  // 2x2 window; row_q / map_q are the window addresses at c=0 of the
  // current output row / at r=c=0 of the current map. Output words are
  // contiguous in iteration order, so the write pointer simply increments.
  logic [DATA_W-1:0] a_q, row_q, map_q, wa_q;

  logic signed [DATA_W+1:0] acc_q;
  logic signed [DATA_W+1:0] rd_ext;
  logic signed [DATA_W+1:0] acc_shr;

  logic degenerate;
  logic last_c, last_r, last_m;
  logic [DATA_W-1:0] two_n;

  assign rd_ext     = $signed({{2{readData[DATA_W-1]}}, readData});
  assign acc_shr    = acc_q >>> 2;
  assign degenerate = (mapsNumber == '0) || (mapSize < DATA_W'(2));
  assign two_n      = {n_q[DATA_W-2:0], 1'b0};

  assign last_c = (c_q == msz_q  - DATA_W'(1));
  assign last_r = (r_q == msz_q  - DATA_W'(1));
  assign last_m = (m_q == maps_q - DATA_W'(1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable) state_d = degenerate ? S_DONE : S_R0;
      S_R0:   state_d = S_R1;
      S_R1:   state_d = S_R2;
      S_R2:   state_d = S_R3;
      S_R3:   state_d = S_ACC;
      S_ACC:  state_d = S_WR;
      S_WR:   state_d = (last_c && last_r && last_m) ? S_DONE : S_R0;
      S_DONE: if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (address buses forced to 0 outside their strobes)
  // -------------------------------------------------------------------------
  always_comb begin
    readEnable  = 1'b0;
    readAddr    = '0;
    writeEnable = 1'b0;
    writeAddr   = '0;
    writeOut    = '0;
    done        = 1'b0;
    case (state_q)
      S_R0: begin readEnable = 1'b1; readAddr = a_q;                      end
      S_R1: begin readEnable = 1'b1; readAddr = a_q + DATA_W'(1);         end
      S_R2: begin readEnable = 1'b1; readAddr = a_q + n_q;                end
      S_R3: begin readEnable = 1'b1; readAddr = a_q + n_q + DATA_W'(1);   end
      S_WR: begin
        writeEnable = 1'b1;
        writeAddr   = wa_q;
        // |sum| <= 4*2^(DATA_W-1), so sum>>>2 always fits in DATA_W
        writeOut    = acc_shr[DATA_W-1:0];
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: job latch, accumulator, counters and pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      maps_q <= '0;
      n_q    <= '0;
      msz_q  <= '0;
      nn_q   <= '0;
      c_q    <= '0;
      r_q    <= '0;
      m_q    <= '0;
      a_q    <= '0;
      row_q  <= '0;
      map_q  <= '0;
      wa_q   <= '0;
      acc_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (enable) begin
          maps_q <= mapsNumber;
          n_q    <= mapSize;
          msz_q  <= mapSize >> 1;
          nn_q   <= mapSize * mapSize;   // wraps like every other address
          c_q    <= '0;
          r_q    <= '0;
          m_q    <= '0;
          a_q    <= inAddress;
          row_q  <= inAddress;
          map_q  <= inAddress;
          wa_q   <= outAddress;
          acc_q  <= '0;
        end
        // readData lags its strobe by one cycle: R1 sees the R0 word, etc.
        S_R1:              acc_q <= rd_ext;
        S_R2, S_R3, S_ACC: acc_q <= acc_q + rd_ext;
        S_WR: begin
          wa_q <= wa_q + DATA_W'(1);
          if (!last_c) begin
            c_q <= c_q + DATA_W'(1);
            a_q <= a_q + DATA_W'(2);
          end else begin
            c_q <= '0;
            if (!last_r) begin
              // next output row starts two input rows down; for odd N the
              // trailing column is skipped implicitly by this jump
              r_q   <= r_q + DATA_W'(1);
              row_q <= row_q + two_n;
              a_q   <= row_q + two_n;
            end else begin
              // next map; for odd N the trailing row is skipped the same way
              r_q   <= '0;
              m_q   <= m_q + DATA_W'(1);
              map_q <= map_q + nn_q;
              row_q <= map_q + nn_q;
              a_q   <= map_q + nn_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_pool_layer.sv
// ---------------------------------------------------------------------------
// Bench for avg_pool_layer. A memory model answers reads one cycle late.
// The reference derives, for every cycle after a start, what each output must
// be from the pooling rules (window address, floor(sum/4), six-cycle cadence)
// and the compare loop checks all outputs against it each cycle.
// Hand-computed literals pin the reference on the directed cases.
// ---------------------------------------------------------------------------
module tb_avg_pool_layer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] mapsNumber, mapSize, inAddress, outAddress;
  logic        readEnable, writeEnable, done;
  logic [15:0] readAddr, writeAddr, writeOut;
  logic [15:0] rdata;

  logic [15:0] mem [65536];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] wlog_a[$], wlog_d[$], rlog[$];
  int          done_cyc;

  always #5 clk = ~clk;

  avg_pool_layer #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mapsNumber(mapsNumber), .mapSize(mapSize),
    .inAddress(inAddress), .outAddress(outAddress),
    .readEnable(readEnable), .readAddr(readAddr), .readData(rdata),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeOut(writeOut),
    .done(done)
  );

  // memory: registered read, data visible the cycle after the strobe
  always @(posedge clk) rdata <= readEnable ? mem[readAddr] : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // floor(sum of 2x2 window / 4), straight from the definition
  function automatic logic [15:0] pool_val(input int a, input int n);
    int s, md;
    s = int'($signed(mem[16'(a)]))     + int'($signed(mem[16'(a + 1)]))
      + int'($signed(mem[16'(a + n)])) + int'($signed(mem[16'(a + n + 1)]));
    md = ((s % 4) + 4) % 4;
    return 16'((s - md) / 4);
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_re"},   32'(readEnable),  0);
    chk({tag, "_ra"},   32'(readAddr),    0);
    chk({tag, "_we"},   32'(writeEnable), 0);
    chk({tag, "_wa"},   32'(writeAddr),   0);
    chk({tag, "_wo"},   32'(writeOut),    0);
    chk({tag, "_done"}, 32'(done),        0);
  endtask

  // Start one job and check every cycle up to and past done.
  // abort_at>0: assert reset after checking that cycle and return.
  task automatic run_op(input int maps, input int n, input int ina, input int outa,
                        input bit hold, input int abort_at);
    int mm, total, T, j, p, m, r, c, a;
    logic        ere, ewe, edone;
    logic [15:0] era, ewa, ewd;
    string       t;
    mm    = n / 2;
    total = (maps == 0 || n < 2) ? 0 : maps * mm * mm;
    T     = 6 * total;
    wlog_a.delete(); wlog_d.delete(); rlog.delete();
    done_cyc = -1;
    @(negedge clk);
    mapsNumber = 16'(maps); mapSize = 16'(n);
    inAddress  = 16'(ina);  outAddress = 16'(outa);
    enable     = 1'b1;
    @(posedge clk);            // start edge = cycle 0
    #1;
    enable = hold;
    // later input changes must be ignored
    mapsNumber = 16'hFFFF; mapSize = 16'h0007; inAddress = 16'h1234; outAddress = 16'h4321;
    for (int k = 1; k <= T + 1; k++) begin
      @(negedge clk);
      ere = 0; ewe = 0; era = 0; ewa = 0; ewd = 0;
      edone = (k == T + 1);
      if (k <= T) begin
        j = (k - 1) / 6; p = (k - 1) % 6;
        m = j / (mm * mm); r = (j / mm) % mm; c = j % mm;
        a = ina + m * n * n + 2 * r * n + 2 * c;
        if (p < 4) begin
          ere = 1;
          era = 16'(a + ((p % 2 == 1) ? 1 : 0) + ((p >= 2) ? n : 0));
        end
        if (p == 5) begin
          ewe = 1; ewa = 16'(outa + j); ewd = pool_val(a, n);
        end
      end
      t = $sformatf("c%0d", k);
      chk({t, "_re"},   32'(readEnable),  32'(ere));
      chk({t, "_ra"},   32'(readAddr),    32'(era));
      chk({t, "_we"},   32'(writeEnable), 32'(ewe));
      chk({t, "_wa"},   32'(writeAddr),   32'(ewa));
      chk({t, "_wo"},   32'(writeOut),    32'(ewd));
      chk({t, "_done"}, 32'(done),        32'(edone));
      chk({t, "_excl"}, 32'(readEnable & writeEnable), 0);
      if (writeEnable) begin wlog_a.push_back(writeAddr); wlog_d.push_back(writeOut); end
      if (readEnable) rlog.push_back(readAddr);
      if (done && done_cyc < 0) done_cyc = k;
      if (abort_at == k) begin
        reset = 1'b1; enable = 1'b0;
        return;
      end
    end
    if (hold) begin
      repeat (2) begin
        @(negedge clk);
        chk("done_hold", 32'(done), 1);
        chk("hold_re",   32'(readEnable | writeEnable), 0);
      end
      enable = 1'b0;
    end
    @(negedge clk);
    chk_idle("after_done");
  endtask

  initial begin
    int bad, rr, cc;
    reset = 1'b1; enable = 1'b0;
    mapsNumber = '0; mapSize = '0; inAddress = '0; outAddress = '0;
    foreach (mem[i]) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1 map, N=4, 0..15 at 500
    for (int i = 0; i < 16; i++) mem[500 + i] = 16'(i);
    run_op(1, 4, 500, 900, 1, 0);
    chk("n4_cnt",  32'(wlog_d.size()), 4);
    chk("n4_a0",   32'(wlog_a[0]), 900);
    chk("n4_a3",   32'(wlog_a[3]), 903);
    chk("n4_d0",   32'(wlog_d[0]), 2);
    chk("n4_d1",   32'(wlog_d[1]), 4);
    chk("n4_d2",   32'(wlog_d[2]), 10);
    chk("n4_d3",   32'(wlog_d[3]), 12);
    chk("n4_done", 32'(done_cyc), 25);

    // N=2 negatives: sum -10 -> -3
    mem[600] = 16'hFFFF; mem[601] = 16'hFFFE; mem[602] = 16'hFFFD; mem[603] = 16'hFFFC;
    run_op(1, 2, 600, 700, 0, 0);
    chk("neg_d", 32'(wlog_d[0]), 32'hFFFD);
    mem[600] = 1; mem[601] = 1; mem[602] = 1; mem[603] = 0;
    run_op(1, 2, 600, 700, 1, 0);
    chk("pos3_d", 32'(wlog_d[0]), 0);

    // odd N=5
    for (int i = 0; i < 25; i++) mem[1000 + i] = 16'((i / 5) * 5 + (i % 5));
    run_op(1, 5, 1000, 1100, 1, 0);
    chk("n5_d0", 32'(wlog_d[0]), 3);
    chk("n5_d1", 32'(wlog_d[1]), 5);
    chk("n5_d2", 32'(wlog_d[2]), 13);
    chk("n5_d3", 32'(wlog_d[3]), 15);
    bad = 0;
    foreach (rlog[i]) begin
      rr = (int'(rlog[i]) - 1000) / 5; cc = (int'(rlog[i]) - 1000) % 5;
      if (rr == 4 || cc == 4) bad++;
    end
    chk("n5_unread", 32'(bad), 0);

    // LeNet chain: 6 maps of 6x6, arbitrary signed data, enable dropped
    for (int i = 0; i < 216; i++) mem[2000 + i] = 16'($urandom);
    run_op(6, 6, 2000, 3000, 0, 0);
    chk("lenet_cnt",  32'(wlog_d.size()), 54);
    chk("lenet_last", 32'(wlog_a[53]), 3053);
    chk("lenet_done", 32'(done_cyc), 325);

    // degenerate jobs
    run_op(1, 1, 500, 900, 0, 0);
    chk("n1_done", 32'(done_cyc), 1);
    chk("n1_rd",   32'(rlog.size() + wlog_d.size()), 0);
    run_op(0, 4, 500, 900, 1, 0);
    chk("m0_done", 32'(done_cyc), 1);
    chk("m0_rd",   32'(rlog.size() + wlog_d.size()), 0);

    // read address wrap
    mem[16'hFFFE] = 10; mem[16'hFFFF] = 20; mem[0] = 30; mem[1] = 40;
    run_op(1, 2, 32'hFFFE, 50, 0, 0);
    chk("wrap_r1", 32'(rlog[1]), 32'hFFFF);
    chk("wrap_r2", 32'(rlog[2]), 0);
    chk("wrap_d",  32'(wlog_d[0]), 25);

    // reset in R2 of the 3rd output (cycle 15), then restart
    run_op(1, 4, 500, 900, 1, 15);
    @(negedge clk);
    chk_idle("abort");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_idle("abort_idle");
    end
    run_op(1, 4, 500, 900, 1, 0);
    chk("restart_a0", 32'(wlog_a[0]), 900);
    chk("restart_d0", 32'(wlog_d[0]), 2);
    chk("restart_done", 32'(done_cyc), 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/avg_pool_layer.md
Name: avg_pool_layer

Overview:
- 2x2 stride-2 average-pooling stage directly downstream of convolution_layer.
- Consumes the feature maps that convolution_layer has written to DMA memory and writes the pooled maps back to memory.
- Uses the same word-at-a-time read/write style on the DMA port.
- Asserts done when the last pooled word has been written.

Parameters:
- DATA_W, 16, width of memory words, samples and addresses.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  start request, sampled only in IDLE.
- mapsNumber  in  DATA_W  number of input feature maps.
- mapSize  in  DATA_W  input map side length N (maps are NxN, row-major).
- inAddress  in  DATA_W  base address of map 0 input.
- outAddress  in  DATA_W  base address of map 0 output.
- readEnable  out  1  memory read strobe.
- readAddr  out  DATA_W  memory read address.
- readData  in  DATA_W  signed read data; valid exactly 1 cycle after readEnable.
- writeEnable  out  1  memory write strobe, 1-cycle pulse per output word.
- writeAddr  out  DATA_W  memory write address.
- writeOut  out  DATA_W  signed pooled value.
- done  out  1  high in DONE state.

Behaviour:
- Reset:
  - State goes to IDLE; all outputs 0; counters and accumulator cleared.
  - Reset mid-operation aborts immediately: no further reads or writes occur.
- Start:
  - In IDLE, enable=1 at an edge latches mapsNumber, mapSize, inAddress and outAddress, then moves to R0.
  - Input changes after the latch edge are ignored until the next start.
- Degenerate cases:
  - If mapsNumber=0 or mapSize<2, go directly IDLE->DONE.
  - In that case there are no reads and no writes.
- Output geometry:
  - M = floor(N/2).
  - For odd N, the last input row and last input column are ignored.
- Iteration order: map m=0..mapsNumber-1, output row r=0..M-1, output column c=0..M-1.
- Per-output sequence (6 cycles):
  - Let A = inAddress + m*N*N + 2r*N + 2c.
  - R0: readEnable=1, readAddr=A.
  - R1: readAddr=A+1; accumulator captures readData (sign-extended).
  - R2: readAddr=A+N; accumulator adds readData.
  - R3: readAddr=A+N+1; accumulator adds readData.
  - ACC: readEnable=0; accumulator adds readData.
  - WR: writeEnable=1, writeAddr=outAddress + m*M*M + r*M + c, writeOut = accumulator >>> 2.
  - After WR, advance (c, r, m) with carries and go to R0. After the last output, go to DONE.
- Arithmetic:
  - The accumulator is DATA_W+2 bits signed, so no overflow is possible.
  - The result is an arithmetic shift right by 2, which rounds toward minus infinity. This result always fits in DATA_W.
- Addresses: all address arithmetic wraps modulo 2^DATA_W.
- Outputs outside strobes:
  - readAddr and writeAddr are don't-care when their strobe is low; the implementation drives them to 0.
  - readEnable and writeEnable are never high in the same cycle.
- Timing:
  - With the start edge at cycle 0, the first readEnable is at cycle 1.
  - done first goes high at cycle 1 + 6*mapsNumber*M*M.
- DONE:
  - done=1 held while enable=1.
  - enable=0 returns to IDLE with done=0.
  - enable held high does not retrigger.
- enable low mid-operation is ignored; the operation completes.

Test Plan:
- 1 map, N=4, mem[500..515]=0..15, outAddress=900:
  - Writes (900,2), (901,4), (902,10), (903,12).
  - done at cycle 25.
- 1 map, N=2, inputs -1,-2,-3,-4:
  - Sum -10, single write of value -3 (0xFFFD).
  - Inputs 1,1,1,0: write 0.
- Odd size, 1 map, N=5, mem = row*5+col:
  - 4 writes of values 3, 5, 13, 15.
  - Addresses with column or row index 4 are never read.
- LeNet chain, mapsNumber=6, N=6 (conv output of 10x10 image, 5x5 filters):
  - 54 writes to outAddress..outAddress+53 in map/row/column order.
  - done at cycle 325; bench compares against a reference model.
- Boundaries:
  - mapSize=1: done at cycle 1, zero strobes.
  - mapsNumber=0: same result.
  - inAddress=0xFFFE: reads wrap to 0x0000 upward.
- Reset asserted during an R2 cycle of the 3rd output:
  - All outputs are 0 the next cycle and stay idle.
  - A fresh enable restarts from output 0 with correct values.
